// File: rtl/cmp_arbiter.sv
// -----------------------------------------------------------------------------
// cmp_arbiter
// Shares one WIDTH-bit magnitude comparator between two requesters:
// port 0 (branch unit) and port 1 (ALU SLT/SLTU path). One request is granted,
// its operands are latched, the RISC-V funct3 condition is evaluated and a
// single registered result is returned with a valid/ready handshake.
//
// Ports
//   clk                   clock, all state on the rising edge
//   rst                   synchronous active-high reset
//   req0_* / req1_*       valid, ready, op (funct3), a (rs1), b (rs2)
//   rsp_valid / rsp_ready result handshake
//   rsp_id                port that issued the request
//   rsp_result            condition outcome (branch taken / SLT bit)
//   rsp_lt/eq/gt          a<b, a==b, a>b (signedness chosen by op)
// -----------------------------------------------------------------------------
module cmp_arbiter #(
    parameter int WIDTH = 32,
    parameter bit FAIR  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_result,
    output logic             rsp_lt,
    output logic             rsp_eq,
    output logic             rsp_gt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CMP  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t           state_r;
    logic             last_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             id_r;

    logic             grant_valid_s;
    logic             grant_id_s;
    logic             signed_s;
    logic             ext_a_s;
    logic             ext_b_s;
    logic [WIDTH:0]   diff_s;
    logic             lt_s;
    logic             eq_s;
    logic             gt_s;
    logic             result_s;
    logic             diff_unused_s;

    // Grant selection: with both ports requesting, round-robin picks the port
    // that was not served last; fixed priority always picks port 0.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid_s = 1'b1;
            if (FAIR == 1'b1) begin
                grant_id_s = ~last_r;
            end else begin
                grant_id_s = 1'b0;
            end
        end else if (req0_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b0;
        end else if (req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    // Ready is only offered while idle, and only to the granted port.
    always_comb begin
        req0_ready = (state_r == ST_IDLE) && grant_valid_s && (grant_id_s == 1'b0);
        req1_ready = (state_r == ST_IDLE) && grant_valid_s && (grant_id_s == 1'b1);
    end

    // Comparator: operands are extended by one bit (sign or zero) so the
    // borrow of the WIDTH+1-bit subtract is the true less-than, with no
    // overflow for full-range operands.
    always_comb begin
        case (op_r)
            3'b011, 3'b110, 3'b111: signed_s = 1'b0;
            default:                signed_s = 1'b1;
        endcase
        ext_a_s       = signed_s & a_r[WIDTH-1];
        ext_b_s       = signed_s & b_r[WIDTH-1];
        diff_s        = {ext_a_s, a_r} - {ext_b_s, b_r};
        lt_s          = diff_s[WIDTH];
        diff_unused_s = ^diff_s[WIDTH-1:0];
        eq_s          = ((a_r ^ b_r) == {WIDTH{1'b0}});
        gt_s          = ~lt_s & ~eq_s;
    end

    // Condition outcome per funct3; lt_s already carries the op's signedness.
    always_comb begin
        case (op_r)
            3'b000:  result_s = eq_s;
            3'b001:  result_s = ~eq_s;
            3'b010:  result_s = lt_s;
            3'b011:  result_s = lt_s;
            3'b100:  result_s = lt_s;
            3'b101:  result_s = ~lt_s;
            3'b110:  result_s = lt_s;
            3'b111:  result_s = ~lt_s;
            default: result_s = 1'b0;
        endcase
    end

    // Control FSM: IDLE accepts one request, CMP registers the comparison,
    // RESP holds the result until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            last_r     <= 1'b1;
            op_r       <= 3'b000;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            id_r       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 1'b0;
            rsp_lt     <= 1'b0;
            rsp_eq     <= 1'b0;
            rsp_gt     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        if (grant_id_s) begin
                            op_r <= req1_op;
                            a_r  <= req1_a;
                            b_r  <= req1_b;
                        end else begin
                            op_r <= req0_op;
                            a_r  <= req0_a;
                            b_r  <= req0_b;
                        end
                        id_r    <= grant_id_s;
                        last_r  <= grant_id_s;
                        state_r <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    rsp_id     <= id_r;
                    rsp_result <= result_s;
                    rsp_lt     <= lt_s;
                    rsp_eq     <= eq_s;
                    rsp_gt     <= gt_s;
                    rsp_valid  <= 1'b1;
                    state_r    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cmp_arbiter
// Self-checking bench for cmp_arbiter. Two instances share clock, reset and
// request inputs: dut_fair (round-robin) carries the scoreboarded traffic,
// dut_fixed (fixed priority) is only observed in the arbitration sequence.
// -----------------------------------------------------------------------------
module tb_cmp_arbiter;

    localparam int W = 32;

    typedef struct {
        logic        port;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exp;   // {result, lt, eq, gt}
    } vec_t;

    typedef struct {
        logic [4:0] exp;    // {id, result, lt, eq, gt}
        int         fire_cyc;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_ready;

    logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_lt, rsp_eq, rsp_gt;
    logic fx_req0_ready, fx_req1_ready, fx_rsp_valid, fx_rsp_id, fx_rsp_result;
    logic fx_rsp_lt, fx_rsp_eq, fx_rsp_gt;

    vec_t vecs[14];
    sb_t  sbq[$];
    logic ids_a[$];
    logic ids_b[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    bit   sb_en = 1'b1;
    bit   seen_valid = 1'b0;

    always #5 clk = ~clk;

    cmp_arbiter #(.WIDTH(W), .FAIR(1'b1)) dut_fair (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt)
    );

    cmp_arbiter #(.WIDTH(W), .FAIR(1'b0)) dut_fixed (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(fx_req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(fx_req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(fx_rsp_valid), .rsp_ready(1'b1), .rsp_id(fx_rsp_id),
        .rsp_result(fx_rsp_result), .rsp_lt(fx_rsp_lt), .rsp_eq(fx_rsp_eq), .rsp_gt(fx_rsp_gt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: scoreboard pop on handshake, or id capture in the
    // arbitration sequence.
    always @(negedge clk) begin
        if (sb_en) begin
            if (req0_valid && req1_valid) chk("ready_excl", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    if (!seen_valid) begin
                        chk("latency", cyc - sbq[0].fire_cyc, 32'd2);
                        seen_valid <= 1'b1;
                    end
                    if (rsp_ready) begin
                        chk("rsp_fields", {27'd0, rsp_id, rsp_result, rsp_lt, rsp_eq, rsp_gt},
                            {27'd0, sbq[0].exp});
                        chk("onehot", $countones({rsp_lt, rsp_eq, rsp_gt}), 32'd1);
                        void'(sbq.pop_front());
                        seen_valid <= 1'b0;
                    end
                end
            end
        end else begin
            if (rsp_valid && rsp_ready) ids_a.push_back(rsp_id);
            if (fx_rsp_valid) ids_b.push_back(fx_rsp_id);
        end
    end

    // Drive one table vector on its port, wait for the grant, push expectation.
    task automatic send(input int i, output int waits);
        @(posedge clk); #1;
        if (vecs[i].port == 1'b0) begin
            req0_valid = 1'b1; req0_op = vecs[i].op; req0_a = vecs[i].a; req0_b = vecs[i].b;
        end else begin
            req1_valid = 1'b1; req1_op = vecs[i].op; req1_a = vecs[i].a; req1_b = vecs[i].b;
        end
        waits = 0;
        @(negedge clk);
        while (!((vecs[i].port == 1'b0) ? req0_ready : req1_ready) && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 20) chk("grant_timeout", waits, 32'd0);
        else sbq.push_back('{exp: {vecs[i].port, vecs[i].exp}, fire_cyc: cyc});
        @(posedge clk); #1;
        if (vecs[i].port == 1'b0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && sbq.size() != 0; k++) @(negedge clk);
        chk("drain", sbq.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_op = 3'b000; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 3'b000; req1_a = '0; req1_b = '0;

        vecs[0]  = '{1'b0, 3'b000, 32'd5,          32'd5,          4'b1010};
        vecs[1]  = '{1'b0, 3'b100, 32'hFFFF_FFFF,  32'd1,          4'b1100};
        vecs[2]  = '{1'b1, 3'b110, 32'hFFFF_FFFF,  32'd1,          4'b0001};
        vecs[3]  = '{1'b1, 3'b111, 32'h8000_0000,  32'h7FFF_FFFF,  4'b1001};
        vecs[4]  = '{1'b0, 3'b010, 32'h8000_0000,  32'h7FFF_FFFF,  4'b1100};
        vecs[5]  = '{1'b1, 3'b011, 32'h0,          32'hFFFF_FFFF,  4'b1100};
        vecs[6]  = '{1'b0, 3'b101, 32'h7FFF_FFFF,  32'h8000_0000,  4'b1001};
        vecs[7]  = '{1'b1, 3'b001, 32'h1234_5678,  32'h1234_5678,  4'b0010};
        vecs[8]  = '{1'b0, 3'b000, 32'd0,          32'd1,          4'b0100};
        vecs[9]  = '{1'b1, 3'b101, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  4'b0100};
        vecs[10] = '{1'b0, 3'b111, 32'd5,          32'd5,          4'b1010};
        vecs[11] = '{1'b1, 3'b100, 32'h8000_0000,  32'h8000_0000,  4'b0010};
        vecs[12] = '{1'b0, 3'b110, 32'd0,          32'd0,          4'b0010};
        vecs[13] = '{1'b1, 3'b010, 32'd1,          32'hFFFF_FFFF,  4'b0001};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_fields", {27'd0, rsp_id, rsp_result, rsp_lt, rsp_eq, rsp_gt}, 32'd0);
        chk("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 14; i++) send(i, w);
        drain();

        // Backpressure: result held stable, no new grant while in RESP
        rsp_ready = 1'b0;
        send(4, w);
        req1_valid = 1'b1; req1_op = vecs[5].op; req1_a = vecs[5].a; req1_b = vecs[5].b;
        for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("hold_fields", {27'd0, rsp_valid, rsp_id, rsp_result, rsp_lt, rsp_eq, rsp_gt},
                {27'd0, 1'b1, 1'b0, vecs[4].exp});
            chk("hold_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0; rsp_ready = 1'b1;
        drain();

        // Reset while in CMP drops the request
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd7; req0_b = 32'd7;
        @(negedge clk);
        chk("pre_rst_ready0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        send(2, w);
        chk("idle_after_rst", w, 32'd0);
        drain();

        // Arbitration with both ports continuously valid
        sb_en = 1'b0;
        ids_a.delete(); ids_b.delete();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 3'b001; req1_a = 32'd1; req1_b = 32'd2;
        for (int k = 0; k < 40 && (ids_a.size() < 4 || ids_b.size() < 3); k++) @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("fair_id%0d", i), {31'd0, (i < ids_a.size()) ? ids_a[i] : 1'bx}, i % 2);
        for (int i = 0; i < 3; i++)
            chk($sformatf("fixed_id%0d", i), {31'd0, (i < ids_b.size()) ? ids_b[i] : 1'bx}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
